// File: rtl/nibble_serial_adder.sv
// Wide adder built from one 4-bit ripple-carry slice, one nibble per clock, LSB first.
// Optional subtract mode (adds port `sub`) when SERIAL_ADDER_SUB_EN is defined.

module ripplecarryadder_4 (
  input  logic [3:0] in1,
  input  logic [3:0] in2,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic c1_s, c2_s, c3_s;

  assign sum[0] = in1[0] ^ in2[0] ^ cin;
  assign c1_s   = (in1[0] & in2[0]) | (cin & (in1[0] ^ in2[0]));
  assign sum[1] = in1[1] ^ in2[1] ^ c1_s;
  assign c2_s   = (in1[1] & in2[1]) | (c1_s & (in1[1] ^ in2[1]));
  assign sum[2] = in1[2] ^ in2[2] ^ c2_s;
  assign c3_s   = (in1[2] & in2[2]) | (c2_s & (in1[2] ^ in2[2]));
  assign sum[3] = in1[3] ^ in2[3] ^ c3_s;
  assign cout   = (in1[3] & in2[3]) | (c3_s & (in1[3] ^ in2[3]));
endmodule

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic                 sub,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t        state;
  logic [W-1:0]  a_q, b_q, sum_q;
  logic          carry_q, cout_q;
  logic [IW-1:0] idx;
  logic          in_ready_r, out_valid_r;
  logic          sub_q;

  logic [W-1:0]  a_sh_s, b_sh_s;
  logic [3:0]    slice_b_s, slice_sum_s;
  logic          slice_cout_s;
  logic          sub_s;
  logic          init_carry_s;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_s = sub;
`else
  assign sub_s = 1'b0;
`endif

  // Subtract is a + ~b + 1, so the initial carry is forced to 1 and cin is ignored.
  assign init_carry_s = sub_s ? 1'b1 : cin;

  assign a_sh_s    = a_q >> {idx, 2'b00};
  assign b_sh_s    = b_q >> {idx, 2'b00};
  assign slice_b_s = sub_q ? ~b_sh_s[3:0] : b_sh_s[3:0];

  ripplecarryadder_4 u_slice (
    .in1  (a_sh_s[3:0]),
    .in2  (slice_b_s),
    .cin  (carry_q),
    .sum  (slice_sum_s),
    .cout (slice_cout_s)
  );

  // Sequencer: accept operands, walk the nibbles, then hold the result until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      a_q         <= {W{1'b0}};
      b_q         <= {W{1'b0}};
      sum_q       <= {W{1'b0}};
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      idx         <= {IW{1'b0}};
      sub_q       <= 1'b0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready_r <= 1'b1;
          if (in_valid && in_ready_r) begin
            a_q        <= a;
            b_q        <= b;
            sub_q      <= sub_s;
            carry_q    <= init_carry_s;
            idx        <= {IW{1'b0}};
            sum_q      <= {W{1'b0}};
            in_ready_r <= 1'b0;
            state      <= RUN;
          end
        end
        RUN: begin
          sum_q[{idx, 2'b00} +: 4] <= slice_sum_s;
          carry_q                  <= slice_cout_s;
          if (idx == LAST) begin
            cout_q      <= slice_cout_s;
            out_valid_r <= 1'b1;
            state       <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign sum       = sum_q;
  assign cout      = cout_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder (NIBBLES=4).
// Subtract vectors run only when SERIAL_ADDER_SUB_EN is defined.

module tb_nibble_serial_adder;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;

  int total = 0;
  int bad = 0;

  nibble_serial_adder #(.NIBBLES(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands for one accept edge, then confirm the block went busy.
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc, input logic ts);
    a = ta; b = tb_; cin = tc; sub = ts; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("busy_after_accept", {31'd0, in_ready}, 32'd0);
  endtask

  // out_valid must rise exactly N cycles after acceptance, then result checked.
  task automatic wait_result(input string tag, input logic [W-1:0] es, input logic ec);
    for (int i = 1; i <= N; i++) begin
      tick();
      check({tag, "_valid_timing"}, {31'd0, out_valid}, (i == N) ? 32'd1 : 32'd0);
    end
    check({tag, "_sum"}, {16'd0, sum}, {16'd0, es});
    check({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
  endtask

  // Full op with out_ready held high: valid for one cycle, then back to idle.
  task automatic do_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                       input logic tc, input logic ts, input logic [W-1:0] es, input logic ec);
    start_op(ta, tb_, tc, ts);
    wait_result(tag, es, ec);
    tick();
    check({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    // Reset held with in_valid asserted
    rst = 1'b1; in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
    tick(); tick(); tick();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_sum", {16'd0, sum}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    tick();
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);

    out_ready = 1'b1;
    do_op("basic", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0);
    do_op("ripple", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1);
    do_op("msb", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1);
    do_op("allones", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1);

    // Backpressure: result must hold, new operands must be refused
    out_ready = 1'b0;
    start_op(16'hAAAA, 16'h1111, 1'b0, 1'b0);
    wait_result("bp", 16'hBBBB, 1'b0);
    in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_hold_sum", {16'd0, sum}, 32'h0000BBBB);
      check("bp_hold_cout", {31'd0, cout}, 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    check("bp_idle_valid", {31'd0, out_valid}, 32'd0);
    check("bp_idle_ready", {31'd0, in_ready}, 32'd1);
    check("bp_idle_sum", {16'd0, sum}, 32'h0000BBBB);
    do_op("after_bp", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0);

    // Reset after two nibbles of an op
    start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    tick(); tick();
    rst = 1'b1;
    tick();
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_sum", {16'd0, sum}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < N + 2; i++) begin
      tick();
      check("mid_rst_no_valid", {31'd0, out_valid}, 32'd0);
      check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    end
    do_op("post_rst", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    do_op("sub1", 16'h1000, 16'h0001, 1'b0, 1'b1, 16'h0FFF, 1'b1);
    do_op("sub2", 16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b0);
    do_op("sub0", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
